// File: rtl/fetch_unit.sv
// Sequential instruction fetch with a 2-entry {pc, word} buffer, credit-limited requests and
// redirect flush. Macro FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect halt/trap.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        misalign
);

  typedef enum logic {StRun, StHalt} state_e;

  state_e      r_state;
  logic [31:0] r_pc;
  logic [1:0]  r_out;
  logic [1:0]  r_drop;
  logic [1:0]  r_count;
  logic        r_head;
  logic [31:0] r_buf_pc   [2];
  logic [31:0] r_buf_data [2];

  logic [31:0] w_target;
  logic        w_misaligned;
  logic [2:0]  w_credit_used;
  logic [1:0]  w_in_flight;
  logic        w_accept;
  logic        w_pop;
  logic        w_push;
  logic        w_drop_beat;
  logic        w_tail;
  logic [31:0] w_oldest_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misalign;
  assign w_target     = redirect_pc;
  assign w_misaligned = |redirect_pc[1:0];
  assign misalign     = r_misalign;
`else
  assign w_target     = {redirect_pc[31:2], redirect_pc[1:0] & 2'b00};
  assign w_misaligned = 1'b0;
  assign misalign     = 1'b0;
`endif

  assign w_credit_used  = {1'b0, r_drop} + {1'b0, r_out} + {1'b0, r_count};
  assign imem_req_valid = rst_n && (r_state == StRun) && !redirect_valid && (w_credit_used < 3'd2);
  assign imem_req_addr  = r_pc;

  assign instr_valid = (r_count != 2'd0) && !redirect_valid;
  assign instr       = r_buf_data[r_head];
  assign instr_pc    = r_buf_pc[r_head];

  assign w_accept    = imem_req_valid && imem_req_ready;
  assign w_pop       = instr_valid && instr_ready;
  assign w_drop_beat = imem_resp_valid && (r_drop != 2'd0);
  assign w_push      = imem_resp_valid && (r_drop == 2'd0);
  assign w_tail      = r_head ^ r_count[0];
  // Requests since the last redirect are sequential, so the oldest one trails the fetch PC.
  assign w_oldest_pc = r_pc - {28'd0, r_out, 2'b00};
  assign w_in_flight = r_drop + r_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StRun;
      r_pc    <= RESET_PC;
      r_out   <= 2'd0;
      r_drop  <= 2'd0;
      r_count <= 2'd0;
      r_head  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_buf_pc[i]   <= 32'd0;
        r_buf_data[i] <= 32'd0;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
    end else if (redirect_valid) begin
      r_pc    <= w_target;
      r_count <= 2'd0;
      r_head  <= 1'b0;
      r_out   <= 2'd0;
      // A response arriving this cycle is discarded and no longer counts as in flight.
      r_drop  <= (imem_resp_valid && w_in_flight != 2'd0) ? w_in_flight - 2'd1 : w_in_flight;
      r_state <= w_misaligned ? StHalt : StRun;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_misalign <= w_misaligned;
`endif
    end else begin
      if (w_accept) r_pc <= r_pc + 32'd4;
      r_out   <= r_out + {1'b0, w_accept} - {1'b0, w_push};
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      if (w_drop_beat) r_drop <= r_drop - 2'd1;
      if (w_pop) r_head <= ~r_head;
      if (w_push) begin
        r_buf_pc[w_tail]   <= w_oldest_pc;
        r_buf_data[w_tail] <= imem_resp_data;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model plus an in-order memory model.
// Honours FETCH_MISALIGN_TRAP_EN in the same way as the design.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'd0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        misalign;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready),
    .misalign        (misalign)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: fetch PC, halt/misalign flags, outstanding PCs, drop count, output buffer.
  logic [31:0] m_pc;
  bit          m_halt;
  bit          m_mis;
  logic [31:0] m_outq[$];
  int          m_drop;
  logic [31:0] m_bpc[$];
  logic [31:0] m_bdata[$];

  // Memory model: in-order responses with a due cycle each.
  int          mem_due[$];
  logic [31:0] mem_addr[$];
  int          cyc;
  int          last_due;
  int          lat_min;
  int          lat_max;

  // Per-step observations for directed checks.
  bit          seen_acc;
  logic [31:0] acc_addr;
  bit          seen_instr;
  logic [31:0] got_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy, input bit mrdy);
    bit          exp_req;
    bit          exp_iv;
    bit          rsp;
    int          due;
    int          fly;
    logic [31:0] opc;
    redirect_valid = rv;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    imem_req_ready = mrdy;
    rsp = (mem_due.size() > 0) && (mem_due[0] <= cyc);
    imem_resp_valid = rsp;
    imem_resp_data  = rsp ? mem_word(mem_addr[0]) : $urandom;
    #1;
    exp_req = !m_halt && !rv && (m_drop + m_outq.size() + m_bpc.size()) < 2;
    exp_iv  = (m_bpc.size() > 0) && !rv;
    checks++;
    if (imem_req_valid !== exp_req) begin
      errors++;
      $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_req);
    end
    if (exp_req) begin
      checks++;
      if (imem_req_addr !== m_pc) begin
        errors++;
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, m_pc);
      end
    end
    checks++;
    if (instr_valid !== exp_iv) begin
      errors++;
      $display("FAIL instr_valid cyc=%0d got=%b exp=%b", cyc, instr_valid, exp_iv);
    end
    if (exp_iv) begin
      checks++;
      if ({instr_pc, instr} !== {m_bpc[0], m_bdata[0]}) begin
        errors++;
        $display("FAIL instr cyc=%0d got=%h/%h exp=%h/%h", cyc, instr_pc, instr, m_bpc[0],
                 m_bdata[0]);
      end
    end
    checks++;
    if (misalign !== m_mis) begin
      errors++;
      $display("FAIL misalign cyc=%0d got=%b exp=%b", cyc, misalign, m_mis);
    end
    seen_acc   = imem_req_valid && mrdy;
    acc_addr   = imem_req_addr;
    seen_instr = instr_valid && rdy;
    got_pc     = instr_pc;
    // Memory bookkeeping driven by the DUT's actual handshakes.
    if (rsp) begin
      void'(mem_due.pop_front());
      void'(mem_addr.pop_front());
    end
    if (seen_acc) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_due.push_back(due);
      mem_addr.push_back(imem_req_addr);
    end
    // Reference model update.
    if (rv) begin
      fly = m_drop + m_outq.size() - (rsp ? 1 : 0);
      m_drop = (fly < 0) ? 0 : fly;
      m_outq.delete();
      m_bpc.delete();
      m_bdata.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      m_pc   = rpc;
      m_halt = (rpc[1:0] != 2'b00);
      m_mis  = m_halt;
`else
      m_pc = rpc & ~32'h3;
`endif
    end else begin
      if (exp_iv && rdy) begin
        void'(m_bpc.pop_front());
        void'(m_bdata.pop_front());
      end
      if (rsp) begin
        if (m_drop > 0) m_drop--;
        else if (m_outq.size() > 0) begin
          opc = m_outq.pop_front();
          m_bpc.push_back(opc);
          m_bdata.push_back(mem_word(opc));
        end
      end
      checks++;
      if (m_bpc.size() > 2) begin
        errors++;
        $display("FAIL overflow cyc=%0d got=%0d entries exp<=2", cyc, m_bpc.size());
      end
      if (exp_req && mrdy) begin
        m_outq.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    instr_ready = 1'b0;
    m_pc = RESET_PC;
    m_halt = 1'b0;
    m_mis = 1'b0;
    m_drop = 0;
    m_outq.delete();
    m_bpc.delete();
    m_bdata.delete();
    mem_due.delete();
    mem_addr.delete();
    last_due = -1;
    cyc = 1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req_valid, instr_valid, instr, instr_pc, misalign} !== 67'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b/%b/%h/%h/%b exp=all zero", imem_req_valid, instr_valid,
               instr, instr_pc, misalign);
    end
    @(negedge clk);
    do_reset();
    #1;
    checks++;
    if (!(imem_req_valid === 1'b1 && imem_req_addr === RESET_PC)) begin
      errors++;
      $display("FAIL first_req got=%b/%h exp=1/%h", imem_req_valid, imem_req_addr, RESET_PC);
    end
    @(negedge clk);
  endtask

  task automatic test_stream();
    int          first = -1;
    logic [31:0] pcs[$];
    do_reset();
    lat_min = 1;
    lat_max = 1;
    for (int c = 0; c < 16; c++) begin
      step(1'b0, 32'd0, 1'b1, 1'b1);
      if (seen_instr) begin
        if (first < 0) first = cyc - 1;
        pcs.push_back(got_pc);
      end
    end
    checks++;
    if (first != 3) begin
      errors++;
      $display("FAIL stream_first_cycle got=%0d exp=3", first);
    end
    checks++;
    if (pcs.size() < 4 || pcs[0] !== 32'd0 || pcs[1] !== 32'd4 || pcs[2] !== 32'd8 ||
        pcs[3] !== 32'd12) begin
      errors++;
      $display("FAIL stream_order got=%p exp=0,4,8,12", pcs);
    end
  endtask

  task automatic test_stall();
    int          acc = 0;
    logic [31:0] pcs[$];
    do_reset();
    lat_min = 1;
    lat_max = 1;
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 32'd0, 1'b0, 1'b1);
      if (seen_acc) acc++;
    end
    checks++;
    if (acc != 2) begin
      errors++;
      $display("FAIL stall_accepts got=%0d exp=2", acc);
    end
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 32'd0, 1'b1, 1'b1);
      if (seen_instr) pcs.push_back(got_pc);
    end
    checks++;
    if (pcs.size() < 3 || pcs[0] !== 32'd0 || pcs[1] !== 32'd4 || pcs[2] !== 32'd8) begin
      errors++;
      $display("FAIL stall_release got=%p exp=0,4,8", pcs);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] pcs[$];
    do_reset();
    lat_min = 3;
    lat_max = 3;
    step(1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b1, 32'h100, 1'b1, 1'b1);
    for (int c = 0; c < 15; c++) begin
      step(1'b0, 32'd0, 1'b1, 1'b1);
      if (seen_instr) pcs.push_back(got_pc);
    end
    checks++;
    if (pcs.size() < 1 || pcs[0] !== 32'h100) begin
      errors++;
      $display("FAIL redirect_target got=%p exp first=00000100", pcs);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] addrs[$];
    do_reset();
    lat_min = 1;
    lat_max = 1;
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 32'd0, 1'b1, 1'b1);
      if (seen_acc) addrs.push_back(acc_addr);
    end
    checks++;
    if (addrs.size() < 2 || addrs[0] !== 32'hFFFF_FFFC || addrs[1] !== 32'd0) begin
      errors++;
      $display("FAIL wrap got=%p exp=fffffffc,00000000", addrs);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] addrs[$];
    do_reset();
    lat_min = 1;
    lat_max = 2;
    for (int c = 0; c < 3; c++) step(1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b1, 32'h102, 1'b1, 1'b1);
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 32'd0, 1'b1, 1'b1);
      if (seen_acc) addrs.push_back(acc_addr);
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++;
    if (addrs.size() != 0 || misalign !== 1'b1) begin
      errors++;
      $display("FAIL misalign_halt got=%0d reqs mis=%b exp=0 reqs mis=1", addrs.size(), misalign);
    end
    addrs.delete();
    step(1'b1, 32'h200, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 32'd0, 1'b1, 1'b1);
      if (seen_acc) addrs.push_back(acc_addr);
    end
    checks++;
    if (addrs.size() < 1 || addrs[0] !== 32'h200 || misalign !== 1'b0) begin
      errors++;
      $display("FAIL misalign_resume got=%p mis=%b exp first=00000200 mis=0", addrs, misalign);
    end
`else
    checks++;
    if (addrs.size() < 1 || addrs[0] !== 32'h100 || misalign !== 1'b0) begin
      errors++;
      $display("FAIL misalign_forced got=%p mis=%b exp first=00000100 mis=0", addrs, misalign);
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat_min = 3;
    lat_max = 3;
    step(1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req_valid, instr_valid, instr, instr_pc, misalign} !== 67'd0) begin
      errors++;
      $display("FAIL reset_mid got=%b/%b/%h/%h/%b exp=all zero", imem_req_valid, instr_valid,
               instr, instr_pc, misalign);
    end
    @(negedge clk);
    do_reset();
    lat_min = 1;
    lat_max = 1;
    step(1'b0, 32'd0, 1'b1, 1'b1);
    checks++;
    if (!(seen_acc && acc_addr === RESET_PC)) begin
      errors++;
      $display("FAIL reset_mid_first got=%b/%h exp=1/%h", seen_acc, acc_addr, RESET_PC);
    end
    for (int c = 0; c < 6; c++) step(1'b0, 32'd0, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    do_reset();
    lat_min = 1;
    lat_max = 3;
    for (int c = 0; c < 500; c++) begin
      rpc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(3, 0) == 0) rpc[1:0] = 2'($urandom_range(3, 1));
      step($urandom_range(11, 0) == 0, rpc, $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
